cpu_bus_responder: RTL and testbench
====================================

// Module: cpu_bus_responder
// PURPOSE
//  Memory-side responder for the CPU nibble bus (memory_write_en/read_en/addr/data).
//  Decodes RAM, VRAM and an I/O window holding interrupt factor flags and masks.
//  Drives interrupt_req back to the CPU. Second read-only VRAM port feeds the LCD path.
// PARAMETERS
//  RAM_WORDS   640      RAM nibbles at 0x000..RAM_WORDS-1
//  VRAM_BASE   12'hE00  first VRAM address
//  VRAM_WORDS  160      VRAM nibbles at VRAM_BASE..VRAM_BASE+VRAM_WORDS-1
//  IO_BASE     12'hF00  base of I/O register window
// PORTS
//  clk                input   1   system clock (CPU 2x clock)
//  reset_n            input   1   reset, synchronous, active-low
//  clk_en             input   1   CPU bus cycle qualifier; bus sampled only when high
//  memory_write_en    input   1   write strobe
//  memory_read_en     input   1   read strobe
//  memory_addr        input   12  nibble address
//  memory_write_data  input   4   write data
//  memory_read_data   output  4   registered read data
//  event_pulse        input   15  interrupt factor sources, 1-clk pulses, sampled every clk
//  interrupt_req      output  15  flag & mask, registered, to CPU
//  vram_rd_addr       input   8   LCD-side VRAM index (0..VRAM_WORDS-1)
//  vram_rd_data       output  4   LCD-side VRAM data, registered
// BEHAVIOUR
//  - Reset: memory_read_data=0, vram_rd_data=0, flags=0, masks=0, interrupt_req=0.
//    RAM/VRAM contents not cleared. Reset mid-read discards the pending read.
//  - Bus acted on only in clk cycles with clk_en=1; other cycles: no state change
//    from bus, memory_read_data holds.
//  - Write has priority: write_en & read_en together -> write performed, no read,
//    memory_read_data holds.
//  - Read latency: data registered at the clk_en edge sampling read_en; valid from the
//    following clk until the next read.
//  - Decode: RAM, VRAM, IO as above; any other address: reads return 4'h0, writes ignored.
//    Address beyond RAM_WORDS / VRAM_WORDS counts as unmapped.
//  - IO map (offset from IO_BASE):
//    0x00 flags[3:0]  0x01 flags[7:4]  0x02 flags[11:8]  0x03 {0,flags[14:12]}
//    0x10..0x13 mask nibbles, same packing; R/W; bit 3 of 0x13 reads 0, write ignored.
//    Other offsets unmapped. Writes to 0x00..0x03 ignored.
//  - Flags: event_pulse[i]=1 sets flags[i] on that clk. Read of a flag nibble returns
//    current value and clears exactly the bits read in the same cycle.
//  - Simultaneous event on a bit being read-cleared: event wins; flag stays 1,
//    read returns pre-event value.
//  - interrupt_req[i] <= flags[i] & masks[i] every clk (1 clk after flag/mask update).
//  - VRAM port: vram_rd_data <= VRAM[vram_rd_addr] every clk, independent of clk_en;
//    out-of-range index returns 0. Same-cycle CPU write -> old data (read-before-write).
//  - Memory modelled as arrays for block-RAM inference; no reset loops over arrays.
// TESTING
//  1 write 0x5 @0x010 (clk_en), then read 0x010 -> memory_read_data=0x5 next clk
//  2 write 0x7 @0x300, read 0x300 -> 0x0; RAM 0x000..0x27F unchanged
//  3 mask write 0x4 @0xF10, pulse event_pulse[2] -> interrupt_req=15'h0004 one clk later;
//    read 0xF00 -> 0x4, flag cleared, interrupt_req=0 next clk
//  4 flags[0]=1, read 0xF00 same clk as event_pulse[0] -> returns 0x1, flags[0] stays 1
//  5 write_en & read_en same cycle @0x020 data 0x9 -> RAM[0x020]=0x9, read_data holds
//  6 write 0xA @0xE05, vram_rd_addr=5 -> vram_rd_data=0xA; assert reset_n=0 during
//    pending read -> read_data=0, masks=0, interrupt_req=0

Source files
------------

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the CPU nibble bus: RAM, VRAM, and an I/O window with
// interrupt factor flags/masks. A second read-only VRAM port feeds the LCD path.
module cpu_bus_responder #(
    parameter int unsigned RAM_WORDS  = 640,
    parameter logic [11:0] VRAM_BASE  = 12'hE00,
    parameter int unsigned VRAM_WORDS = 160,
    parameter logic [11:0] IO_BASE    = 12'hF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        memory_write_en,
    input  logic        memory_read_en,
    input  logic [11:0] memory_addr,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    input  logic [14:0] event_pulse,
    output logic [14:0] interrupt_req,
    input  logic [7:0]  vram_rd_addr,
    output logic [3:0]  vram_rd_data
);

    localparam int          RAM_AW     = $clog2(RAM_WORDS);
    localparam int          VRAM_AW    = $clog2(VRAM_WORDS);
    localparam logic [11:0] RAM_LIMIT  = 12'(RAM_WORDS);
    localparam logic [11:0] VRAM_LIMIT = 12'(VRAM_WORDS);

    logic [3:0]  ram_q  [RAM_WORDS];
    logic [3:0]  vram_q [VRAM_WORDS];

    logic [3:0]  rd_data_q, rd_data_d;
    logic [3:0]  vram_rd_q, vram_rd_d;
    logic [14:0] flags_q, flags_d;
    logic [14:0] masks_q, masks_d;
    logic [14:0] irq_q;

    logic [11:0] vram_off, io_off;
    logic        in_ram, in_vram, io_flag, io_mask;
    logic        bus_wr, bus_rd;
    logic [RAM_AW-1:0]  ram_idx;
    logic [VRAM_AW-1:0] vram_idx;
    logic [1:0]  nib_sel;
    logic [3:0]  rd_val;
    logic [14:0] flag_clr;

    assign vram_off = memory_addr - VRAM_BASE;
    assign io_off   = memory_addr - IO_BASE;
    assign in_ram   = memory_addr < RAM_LIMIT;
    assign in_vram  = (memory_addr >= VRAM_BASE) && (vram_off < VRAM_LIMIT);
    assign io_flag  = (memory_addr >= IO_BASE) && (io_off < 12'h004);
    assign io_mask  = (memory_addr >= IO_BASE) && (io_off >= 12'h010) && (io_off < 12'h014);
    assign ram_idx  = memory_addr[RAM_AW-1:0];
    assign vram_idx = vram_off[VRAM_AW-1:0];
    assign nib_sel  = io_off[1:0];

    // Write wins over a simultaneous read strobe; both are qualified by clk_en.
    assign bus_wr = clk_en && memory_write_en;
    assign bus_rd = clk_en && memory_read_en && !memory_write_en;

    always_comb begin
        rd_val = 4'h0;
        if (in_ram) begin
            rd_val = ram_q[ram_idx];
        end else if (in_vram) begin
            rd_val = vram_q[vram_idx];
        end else if (io_flag) begin
            case (nib_sel)
                2'd0:    rd_val = flags_q[3:0];
                2'd1:    rd_val = flags_q[7:4];
                2'd2:    rd_val = flags_q[11:8];
                default: rd_val = {1'b0, flags_q[14:12]};
            endcase
        end else if (io_mask) begin
            case (nib_sel)
                2'd0:    rd_val = masks_q[3:0];
                2'd1:    rd_val = masks_q[7:4];
                2'd2:    rd_val = masks_q[11:8];
                default: rd_val = {1'b0, masks_q[14:12]};
            endcase
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        flag_clr  = '0;
        masks_d   = masks_q;
        if (bus_rd) begin
            rd_data_d = rd_val;
            if (io_flag) begin
                case (nib_sel)
                    2'd0:    flag_clr[3:0]   = 4'hF;
                    2'd1:    flag_clr[7:4]   = 4'hF;
                    2'd2:    flag_clr[11:8]  = 4'hF;
                    default: flag_clr[14:12] = 3'h7;
                endcase
            end
        end
        if (bus_wr && io_mask) begin
            case (nib_sel)
                2'd0:    masks_d[3:0]   = memory_write_data;
                2'd1:    masks_d[7:4]   = memory_write_data;
                2'd2:    masks_d[11:8]  = memory_write_data;
                default: masks_d[14:12] = memory_write_data[2:0];
            endcase
        end
        // A same-cycle event re-sets a bit the read just cleared.
        flags_d = (flags_q & ~flag_clr) | event_pulse;
    end

    always_comb begin
        vram_rd_d = 4'h0;
        if ({4'h0, vram_rd_addr} < VRAM_LIMIT) begin
            vram_rd_d = vram_q[vram_rd_addr[VRAM_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && bus_wr && in_ram) begin
            ram_q[ram_idx] <= memory_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && bus_wr && in_vram) begin
            vram_q[vram_idx] <= memory_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
            vram_rd_q <= '0;
            flags_q   <= '0;
            masks_q   <= '0;
            irq_q     <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            vram_rd_q <= vram_rd_d;
            flags_q   <= flags_d;
            masks_q   <= masks_d;
            irq_q     <= flags_q & masks_q;
        end
    end

    assign memory_read_data = rd_data_q;
    assign vram_rd_data     = vram_rd_q;
    assign interrupt_req    = irq_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized bench for cpu_bus_responder against an address-map level reference model.
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        memory_write_en;
    logic        memory_read_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;
    logic [14:0] event_pulse;
    logic [14:0] interrupt_req;
    logic [7:0]  vram_rd_addr;
    logic [3:0]  vram_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    int m_ram  [640];
    int m_vram [160];
    int m_rd, m_vrd, m_irq, m_flags, m_masks;

    cpu_bus_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clk_en            (clk_en),
        .memory_write_en   (memory_write_en),
        .memory_read_en    (memory_read_en),
        .memory_addr       (memory_addr),
        .memory_write_data (memory_write_data),
        .memory_read_data  (memory_read_data),
        .event_pulse       (event_pulse),
        .interrupt_req     (interrupt_req),
        .vram_rd_addr      (vram_rd_addr),
        .vram_rd_data      (vram_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_read(input int a);
        int k;
        if (a < 640) return m_ram[a];
        if (a >= 'hE00 && a < 'hEA0) return m_vram[a - 'hE00];
        if (a >= 'hF00 && a <= 'hF03) begin
            k = a - 'hF00;
            return (m_flags >> (4 * k)) & 'hF;
        end
        if (a >= 'hF10 && a <= 'hF13) begin
            k = a - 'hF10;
            return (m_masks >> (4 * k)) & 'hF;
        end
        return 0;
    endfunction

    // One clock: drive inputs, predict, clock, compare all registered outputs.
    task automatic cyc(input bit rst_b, input bit ce, input bit we, input bit re,
                       input int a, input int d, input int ev, input int va);
        int n_rd, n_vrd, n_irq, n_flags, n_masks, k;
        reset_n           = rst_b;
        clk_en            = ce;
        memory_write_en   = we;
        memory_read_en    = re;
        memory_addr       = 12'(a);
        memory_write_data = 4'(d);
        event_pulse       = 15'(ev);
        vram_rd_addr      = 8'(va);
        if (!rst_b) begin
            n_rd = 0; n_vrd = 0; n_irq = 0; n_flags = 0; n_masks = 0;
        end else begin
            n_rd    = m_rd;
            n_irq   = m_flags & m_masks;
            n_vrd   = (va < 160) ? m_vram[va] : 0;
            n_flags = (m_flags | ev) & 'h7FFF;
            n_masks = m_masks;
            if (ce && we) begin
                if (a < 640) m_ram[a] = d;
                else if (a >= 'hE00 && a < 'hEA0) m_vram[a - 'hE00] = d;
                else if (a >= 'hF10 && a <= 'hF13) begin
                    k = a - 'hF10;
                    n_masks = ((m_masks & ~('hF << (4 * k))) | (d << (4 * k))) & 'h7FFF;
                end
            end else if (ce && re) begin
                n_rd = model_read(a);
                if (a >= 'hF00 && a <= 'hF03) begin
                    k = a - 'hF00;
                    n_flags = ((m_flags & ~('hF << (4 * k))) | ev) & 'h7FFF;
                end
            end
        end
        @(posedge clk);
        #1;
        m_rd = n_rd; m_vrd = n_vrd; m_irq = n_irq; m_flags = n_flags; m_masks = n_masks;
        check_eq("read_data", 32'(memory_read_data), 32'(m_rd));
        check_eq("vram_rd_data", 32'(vram_rd_data), 32'(m_vrd));
        check_eq("interrupt_req", 32'(interrupt_req), 32'(m_irq));
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 9))
            0, 1:    return $urandom_range(0, 15);
            2:       return $urandom_range(630, 645);
            3:       return $urandom_range('hE00, 'hE0F);
            4:       return $urandom_range('hE98, 'hEA3);
            5, 6:    return $urandom_range('hF00, 'hF05);
            7:       return $urandom_range('hF0E, 'hF15);
            8:       return $urandom_range('hF16, 'hFFF);
            default: return $urandom_range(0, 'hFFF);
        endcase
    endfunction

    initial begin
        int ev;
        reset_n = 1'b0; clk_en = 1'b0; memory_write_en = 1'b0; memory_read_en = 1'b0;
        memory_addr = '0; memory_write_data = '0; event_pulse = '0; vram_rd_addr = '0;
        m_rd = 0; m_vrd = 0; m_irq = 0; m_flags = 0; m_masks = 0;
        for (int i = 0; i < 640; i++) m_ram[i] = 0;
        for (int i = 0; i < 160; i++) m_vram[i] = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_read_data", 32'(memory_read_data), 32'h0);
        check_eq("reset_irq", 32'(interrupt_req), 32'h0);

        for (int i = 0; i < 640; i++) cyc(1, 1, 1, 0, i, $urandom_range(0, 15), 0, 200);
        for (int i = 0; i < 160; i++) cyc(1, 1, 1, 0, 'hE00 + i, $urandom_range(0, 15), 0, i);

        // Basic RAM write/read.
        cyc(1, 1, 1, 0, 'h010, 5, 0, 0);
        cyc(1, 1, 0, 1, 'h010, 0, 0, 0);
        check_eq("t1_ram_read", 32'(memory_read_data), 32'h5);

        // Unmapped write dropped and reads 0; top RAM word intact.
        cyc(1, 1, 1, 0, 'h300, 7, 0, 0);
        cyc(1, 1, 0, 1, 'h300, 0, 0, 0);
        check_eq("t2_unmapped_read", 32'(memory_read_data), 32'h0);
        cyc(1, 1, 0, 1, 'h27F, 0, 0, 0);

        // Mask + event -> interrupt, then read-clear.
        cyc(1, 1, 1, 0, 'hF10, 4, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 'h0004, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t3_irq_set", 32'(interrupt_req), 32'h0004);
        cyc(1, 1, 0, 1, 'hF00, 0, 0, 0);
        check_eq("t3_flag_read", 32'(memory_read_data), 32'h4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t3_irq_cleared", 32'(interrupt_req), 32'h0);

        // Event coincident with read-clear keeps the flag.
        cyc(1, 0, 0, 0, 0, 0, 'h0001, 0);
        cyc(1, 1, 0, 1, 'hF00, 0, 'h0001, 0);
        check_eq("t4_read_pre_event", 32'(memory_read_data), 32'h1);
        cyc(1, 1, 0, 1, 'hF00, 0, 0, 0);
        check_eq("t4_flag_kept", 32'(memory_read_data), 32'h1);

        // Write priority over read.
        cyc(1, 1, 1, 1, 'h020, 9, 0, 0);
        check_eq("t5_read_holds", 32'(memory_read_data), 32'h1);
        cyc(1, 1, 0, 1, 'h020, 0, 0, 0);
        check_eq("t5_write_done", 32'(memory_read_data), 32'h9);

        // Bit 3 of the top mask nibble is not stored.
        cyc(1, 1, 1, 0, 'hF13, 'hF, 0, 0);
        cyc(1, 1, 0, 1, 'hF13, 0, 0, 0);
        check_eq("mask_top_nibble", 32'(memory_read_data), 32'h7);

        // VRAM LCD port, then reset during a pending read.
        cyc(1, 1, 1, 0, 'hE05, 'hA, 0, 5);
        cyc(1, 0, 0, 0, 0, 0, 0, 5);
        check_eq("t6_vram_port", 32'(vram_rd_data), 32'hA);
        cyc(1, 1, 1, 0, 'hF10, 4, 'h0004, 5);
        cyc(1, 1, 0, 1, 'h010, 0, 0, 5);
        cyc(0, 1, 0, 1, 'h020, 0, 0, 5);
        check_eq("t6_reset_read", 32'(memory_read_data), 32'h0);
        check_eq("t6_reset_irq", 32'(interrupt_req), 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 'h0004, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t6_masks_cleared", 32'(interrupt_req), 32'h0);
        cyc(1, 1, 0, 1, 'h010, 0, 0, 0);
        check_eq("ram_survives_reset", 32'(memory_read_data), 32'h5);

        for (int i = 0; i < 4000; i++) begin
            ev = ($urandom_range(0, 3) == 0) ? int'($urandom & $urandom & 'h7FFF) : 0;
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                rand_addr(), $urandom_range(0, 15), ev, $urandom_range(0, 170));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
